// File: rtl/fp_pkg.sv
// Shared types and fixed-point constants for the radial fingerprint front end.
package fp_pkg;

   localparam int COORD_FRAC  = 16;
   localparam int R2_FRAC     = 2*COORD_FRAC;
   localparam int COORD_W_DEF = 24;
   localparam int R2_W_DEF    = 2*COORD_W_DEF+4;

   typedef logic signed [COORD_W_DEF-1:0] coord_t;
   typedef logic        [R2_W_DEF-1:0]    r2_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/pair_dist_sq.sv
// Stall-able 3-stage pipe: S1 coordinate differences, S2 squares, S3 sum and cutoff compare.
module pair_dist_sq #(
   parameter int COORD_W = 24,
   parameter int IDX_W   = 3,
   parameter int R2_W    = 2*COORD_W+4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      adv_i,
   input  logic                      in_valid_i,
   input  logic [IDX_W-1:0]          in_i_i,
   input  logic [IDX_W-1:0]          in_j_i,
   input  logic signed [COORD_W-1:0] xi_i,
   input  logic signed [COORD_W-1:0] yi_i,
   input  logic signed [COORD_W-1:0] zi_i,
   input  logic signed [COORD_W-1:0] xj_i,
   input  logic signed [COORD_W-1:0] yj_i,
   input  logic signed [COORD_W-1:0] zj_i,
   input  logic [R2_W-1:0]           rc2_i,
   output logic                      s1_valid_o,
   output logic                      s2_valid_o,
   output logic                      keep_o,
   output logic [IDX_W-1:0]          i_o,
   output logic [IDX_W-1:0]          j_o,
   output logic [R2_W-1:0]           r2_o
);

   localparam int DW = COORD_W+1;
   localparam int SW = 2*COORD_W+2;

   function automatic logic signed [DW-1:0] diff(input logic signed [COORD_W-1:0] a,
                                                 input logic signed [COORD_W-1:0] b);
      return {a[COORD_W-1], a} - {b[COORD_W-1], b};
   endfunction

   // Sign-extend to full product width so the square is exact, then keep it as unsigned.
   function automatic logic [SW-1:0] square(input logic signed [DW-1:0] d);
      logic signed [2*DW-1:0] e;
      e = {{DW{d[DW-1]}}, d};
      e = e * e;
      return e;
   endfunction

   logic                   s1_v_q, s2_v_q;
   logic [IDX_W-1:0]       s1_i_q, s1_j_q, s2_i_q, s2_j_q;
   logic signed [DW-1:0]   dx_q, dy_q, dz_q;
   logic [SW-1:0]          sx_q, sy_q, sz_q;
   logic [R2_W-1:0]        r2_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q <= 1'b0;
         s1_i_q <= '0;
         s1_j_q <= '0;
         dx_q   <= '0;
         dy_q   <= '0;
         dz_q   <= '0;
         s2_v_q <= 1'b0;
         s2_i_q <= '0;
         s2_j_q <= '0;
         sx_q   <= '0;
         sy_q   <= '0;
         sz_q   <= '0;
      end else if (adv_i) begin
         s1_v_q <= in_valid_i;
         s1_i_q <= in_i_i;
         s1_j_q <= in_j_i;
         dx_q   <= diff(xi_i, xj_i);
         dy_q   <= diff(yi_i, yj_i);
         dz_q   <= diff(zi_i, zj_i);
         s2_v_q <= s1_v_q;
         s2_i_q <= s1_i_q;
         s2_j_q <= s1_j_q;
         sx_q   <= square(dx_q);
         sy_q   <= square(dy_q);
         sz_q   <= square(dz_q);
      end
   end

   assign r2_sum = {{(R2_W-SW){1'b0}}, sx_q} + {{(R2_W-SW){1'b0}}, sy_q}
                 + {{(R2_W-SW){1'b0}}, sz_q};

   assign s1_valid_o = s1_v_q;
   assign s2_valid_o = s2_v_q;
   assign keep_o     = s2_v_q && (r2_sum < rc2_i);
   assign i_o        = s2_i_q;
   assign j_o        = s2_j_q;
   assign r2_o       = r2_sum;

endmodule

// File: rtl/neighbor_pair_gen.sv
// Holds atom coordinates, sweeps ordered pairs i-major and streams pairs inside the cutoff.
module neighbor_pair_gen
   import fp_pkg::*;
#(
   parameter int NUM_ATOMS = 8,
   parameter int COORD_W   = 24,
   parameter int IDX_W     = $clog2(NUM_ATOMS),
   parameter int R2_W      = 2*COORD_W+4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ld_valid,
   input  logic [IDX_W-1:0]          ld_addr,
   input  logic signed [COORD_W-1:0] ld_x,
   input  logic signed [COORD_W-1:0] ld_y,
   input  logic signed [COORD_W-1:0] ld_z,
   input  logic                      start,
   input  logic [R2_W-1:0]           rc2,
   output logic                      busy,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [IDX_W-1:0]          out_i,
   output logic [IDX_W-1:0]          out_j,
   output logic [R2_W-1:0]           out_r2,
   output logic                      done,
   output logic [2*IDX_W:0]          pair_count
);

   localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_ATOMS-1);
   localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(NUM_ATOMS);

   if (R2_FRAC != 2*COORD_FRAC || R2_W < 2*COORD_W+4 || NUM_ATOMS < 2) begin : g_bad_cfg
      $error("neighbor_pair_gen: inconsistent parameters");
   end

   state_e                    state_q, state_d;
   logic signed [COORD_W-1:0] x_q [NUM_ATOMS];
   logic signed [COORD_W-1:0] y_q [NUM_ATOMS];
   logic signed [COORD_W-1:0] z_q [NUM_ATOMS];
   logic [R2_W-1:0]           rc2_q;
   logic [IDX_W-1:0]          i_q, i_d, j_q, j_d;
   logic [2*IDX_W:0]          pc_q, pc_d;
   logic                      out_valid_q;
   logic [IDX_W-1:0]          out_i_q, out_j_q;
   logic [R2_W-1:0]           out_r2_q;

   logic                      adv, xfer, start_acc, issue, slot_valid, last_slot, pipe_empty;
   logic                      ld_ok;
   logic                      s1_v, s2_v, keep;
   logic [IDX_W-1:0]          p_i, p_j;
   logic [R2_W-1:0]           p_r2;

   // The whole pipe, including issue, freezes while a held output waits for ready.
   assign adv        = !(out_valid_q && !out_ready);
   assign xfer       = out_valid_q && out_ready;
   assign start_acc  = start && (state_q == ST_IDLE);
   assign issue      = (state_q == ST_SWEEP) && adv;
   assign slot_valid = issue && (i_q != j_q);
   assign last_slot  = (i_q == LAST) && (j_q == LAST);
   assign pipe_empty = !s1_v && !s2_v && !out_valid_q;
   assign ld_ok      = ld_valid && (state_q == ST_IDLE) && ({1'b0, ld_addr} < N_EXT);

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      pc_d    = pc_q;
      unique case (state_q)
         ST_IDLE:  if (start_acc) state_d = ST_SWEEP;
         ST_SWEEP: if (issue && last_slot) state_d = ST_DRAIN;
         ST_DRAIN: if (pipe_empty) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (start_acc) begin
         i_d  = '0;
         j_d  = '0;
         pc_d = '0;
      end else begin
         if (issue) begin
            if (j_q == LAST) begin
               j_d = '0;
               i_d = last_slot ? '0 : i_q + 1'b1;
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         if (xfer) pc_d = pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         pc_q    <= '0;
         rc2_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         pc_q    <= pc_d;
         if (start_acc) rc2_q <= rc2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_ATOMS; k++) begin
            x_q[k] <= '0;
            y_q[k] <= '0;
            z_q[k] <= '0;
         end
      end else if (ld_ok) begin
         x_q[ld_addr] <= ld_x;
         y_q[ld_addr] <= ld_y;
         z_q[ld_addr] <= ld_z;
      end
   end

   pair_dist_sq #(
      .COORD_W (COORD_W),
      .IDX_W   (IDX_W),
      .R2_W    (R2_W)
   ) u_pipe (
      .clk        (clk),
      .rst_n      (rst_n),
      .adv_i      (adv),
      .in_valid_i (slot_valid),
      .in_i_i     (i_q),
      .in_j_i     (j_q),
      .xi_i       (x_q[i_q]),
      .yi_i       (y_q[i_q]),
      .zi_i       (z_q[i_q]),
      .xj_i       (x_q[j_q]),
      .yj_i       (y_q[j_q]),
      .zj_i       (z_q[j_q]),
      .rc2_i      (rc2_q),
      .s1_valid_o (s1_v),
      .s2_valid_o (s2_v),
      .keep_o     (keep),
      .i_o        (p_i),
      .j_o        (p_j),
      .r2_o       (p_r2)
   );

   // Output register doubles as pipeline stage 3; its data only changes on advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_i_q     <= '0;
         out_j_q     <= '0;
         out_r2_q    <= '0;
      end else if (adv) begin
         out_valid_q <= keep;
         if (keep) begin
            out_i_q  <= p_i;
            out_j_q  <= p_j;
            out_r2_q <= p_r2;
         end
      end
   end

   assign busy       = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
   assign done       = (state_q == ST_DONE);
   assign out_valid  = out_valid_q;
   assign out_i      = out_i_q;
   assign out_j      = out_j_q;
   assign out_r2     = out_r2_q;
   assign pair_count = pc_q;

endmodule

// File: tb/tb_neighbor_pair_gen.sv
// Self-checking bench for neighbor_pair_gen against a plain-arithmetic pair-list model.
module tb_neighbor_pair_gen;
   import fp_pkg::*;

   localparam int N  = 8;
   localparam int CW = 24;
   localparam int IW = 3;
   localparam int RW = 52;
   localparam int EW = IW + IW + RW;
   localparam longint ONE = 64'h10000;
   localparam logic [RW-1:0] R2_ONE = 52'h1_0000_0000;
   localparam logic [RW-1:0] R2_MAX = {RW{1'b1}};

   logic          clk, rst_n;
   logic          ld_valid;
   logic [IW-1:0] ld_addr;
   coord_t        ld_x, ld_y, ld_z;
   logic          start;
   r2_t           rc2;
   logic          busy, out_valid, out_ready, done;
   logic [IW-1:0] out_i, out_j;
   r2_t           out_r2;
   logic [2*IW:0] pair_count;

   neighbor_pair_gen #(.NUM_ATOMS(N), .COORD_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld_valid   (ld_valid),
      .ld_addr    (ld_addr),
      .ld_x       (ld_x),
      .ld_y       (ld_y),
      .ld_z       (ld_z),
      .start      (start),
      .rc2        (rc2),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_i      (out_i),
      .out_j      (out_j),
      .out_r2     (out_r2),
      .done       (done),
      .pair_count (pair_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   longint        mx [N];
   longint        my [N];
   longint        mz [N];
   logic [EW-1:0] exp_q [$];
   int            checks = 0;
   int            errors = 0;
   r2_t           first_r2;

   task automatic clear_model();
      for (int k = 0; k < N; k++) begin
         mx[k] = 0; my[k] = 0; mz[k] = 0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_x = '0; ld_y = '0; ld_z = '0;
      start = 1'b0; rc2 = '0; out_ready = 1'b1;
      clear_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_atom(input int idx, input longint x, input longint y, input longint z);
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = IW'(idx);
      ld_x = coord_t'(x); ld_y = coord_t'(y); ld_z = coord_t'(z);
      mx[idx] = x; my[idx] = y; mz[idx] = z;
      @(posedge clk);
      #1 ld_valid = 1'b0;
   endtask

   task automatic load_t1();
      load_atom(0, 0, 0, 0);
      load_atom(1, ONE, 0, 0);
      for (int k = 2; k < N; k++) load_atom(k, 10*k*ONE, 0, 0);
   endtask

   // Expected stream: every ordered pair i!=j, i-major, j ascending, strictly inside the cutoff.
   task automatic build_expected(input r2_t rc2_v);
      longint dx, dy, dz, r2;
      exp_q.delete();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (i != j) begin
               dx = mx[i] - mx[j]; dy = my[i] - my[j]; dz = mz[i] - mz[j];
               r2 = dx*dx + dy*dy + dz*dz;
               if (r2 < longint'(rc2_v)) exp_q.push_back({IW'(i), IW'(j), RW'(r2)});
            end
   endtask

   task automatic run_sweep(input r2_t rc2_v, input bit rand_ready, input int inject_cyc,
                            input string name, output int got, output int done_cyc);
      int            exp_n, cyc;
      bit            seen_done, stalled;
      logic [EW-1:0] e, prev;
      build_expected(rc2_v);
      exp_n = exp_q.size();
      got = 0; done_cyc = 0; seen_done = 0; stalled = 0; prev = '0;
      @(negedge clk);
      start = 1'b1; rc2 = rc2_v; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; rc2 = '0;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
      end
      cyc = 1;
      while (!seen_done && cyc < 3000) begin
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || {out_i, out_j, out_r2} !== prev) begin
               errors++;
               $display("FAIL %s stall_hold: got v=%b %h want v=1 %h", name, out_valid,
                        {out_i, out_j, out_r2}, prev);
            end
         end
         if (done) begin
            seen_done = 1; done_cyc = cyc;
         end else begin
            if (cyc == inject_cyc) begin
               start = 1'b1; rc2 = '0; ld_valid = 1'b1; ld_addr = 3'd1;
               ld_x = coord_t'(50*ONE); ld_y = '0; ld_z = '0;
            end else begin
               start = 1'b0; ld_valid = 1'b0;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
               got++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL %s extra_pair: got (%0d,%0d,%h) want none", name, out_i, out_j, out_r2);
               end else begin
                  e = exp_q.pop_front();
                  if ({out_i, out_j, out_r2} !== e) begin
                     errors++;
                     $display("FAIL %s pair: got (%0d,%0d,%h) want (%0d,%0d,%h)", name, out_i, out_j,
                              out_r2, e[EW-1 -: IW], e[RW +: IW], e[RW-1:0]);
                  end
               end
               if (got == 1) first_r2 = out_r2;
            end
            stalled = out_valid && !out_ready;
            prev = {out_i, out_j, out_r2};
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0; ld_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (!seen_done) begin
         errors++; $display("FAIL %s done_timeout: got no done want done within 3000", name);
      end else begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++; $display("FAIL %s missing_pairs: got %0d want %0d", name, got, exp_n);
         end
         checks++;
         if (int'(pair_count) != exp_n || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s end_state: got count=%0d busy=%b valid=%b want count=%0d busy=0 valid=0",
                     name, pair_count, busy, out_valid, exp_n);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || int'(pair_count) != exp_n) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b count=%0d want done=0 count=%0d", name, done,
                     pair_count, exp_n);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({busy, out_valid, done, pair_count, out_i, out_j, out_r2} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b v=%b done=%b cnt=%0d i=%0d j=%0d r2=%h want all 0",
                  busy, out_valid, done, pair_count, out_i, out_j, out_r2);
      end
   endtask

   task automatic test_basic();
      int got, dc;
      load_t1();
      run_sweep(4*R2_ONE, 0, -1, "t1", got, dc);
      checks++;
      if (got != 2 || first_r2 !== R2_ONE) begin
         errors++; $display("FAIL t1_pairs: got %0d r2=%h want 2 r2=%h", got, first_r2, R2_ONE);
      end
      checks++;
      if (dc < 64 || dc > 70) begin
         errors++; $display("FAIL t1_latency: got %0d cycles want 64..70", dc);
      end
   endtask

   task automatic test_cutoff();
      int got, dc;
      load_atom(1, 2*ONE, 0, 0);
      run_sweep(4*R2_ONE, 0, -1, "t2_equal", got, dc);
      checks++;
      if (got != 0) begin
         errors++; $display("FAIL t2_equal_count: got %0d want 0", got);
      end
      run_sweep(4*R2_ONE + 1, 0, -1, "t2_above", got, dc);
      checks++;
      if (got != 2 || first_r2 !== 4*R2_ONE) begin
         errors++; $display("FAIL t2_above: got %0d r2=%h want 2 r2=%h", got, first_r2, 4*R2_ONE);
      end
      run_sweep('0, 0, -1, "t2_zero", got, dc);
      checks++;
      if (got != 0) begin
         errors++; $display("FAIL t2_zero_count: got %0d want 0", got);
      end
   endtask

   task automatic test_backpressure();
      int got, dc;
      for (int k = 0; k < N; k++)
         load_atom(k, $urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF));
      load_atom(5, mx[2], my[2], mz[2]);
      run_sweep(R2_MAX, 1, -1, "t3", got, dc);
      checks++;
      if (got != N*(N-1)) begin
         errors++; $display("FAIL t3_count: got %0d want %0d", got, N*(N-1));
      end
   endtask

   task automatic test_random_cutoff();
      int got, dc;
      r2_t rc;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < N; k++)
            load_atom(k, longint'($urandom_range(0, 4*ONE)) - 2*ONE,
                      longint'($urandom_range(0, 4*ONE)) - 2*ONE,
                      longint'($urandom_range(0, 4*ONE)) - 2*ONE);
         rc = r2_t'($urandom_range(1, 16)) * R2_ONE + r2_t'($urandom);
         run_sweep(rc, 1, -1, "rand", got, dc);
      end
   endtask

   task automatic test_extremes();
      int got, dc;
      longint lo, hi;
      lo = -(longint'(1) << (CW-1));
      hi = (longint'(1) << (CW-1)) - 1;
      load_atom(0, lo, lo, lo);
      load_atom(1, hi, hi, hi);
      run_sweep(R2_MAX, 0, -1, "t4", got, dc);
      checks++;
      if (first_r2 !== 52'h2FFFFFA000003) begin
         errors++; $display("FAIL t4_max_r2: got %h want %h", first_r2, 52'h2FFFFFA000003);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int got, dc;
      load_t1();
      @(negedge clk);
      start = 1'b1; rc2 = 4*R2_ONE;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, done, pair_count} !== '0) begin
         errors++;
         $display("FAIL t5_abort: got v=%b busy=%b done=%b cnt=%0d want all 0", out_valid, busy, done,
                  pair_count);
      end
      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      load_t1();
      run_sweep(4*R2_ONE, 0, -1, "t5", got, dc);
      checks++;
      if (got != 2) begin
         errors++; $display("FAIL t5_count: got %0d want 2", got);
      end
   endtask

   task automatic test_busy_ignore();
      int got, dc;
      run_sweep(4*R2_ONE, 0, 10, "t6_inject", got, dc);
      run_sweep(4*R2_ONE, 0, -1, "t6_after", got, dc);
      checks++;
      if (got != 2 || first_r2 !== R2_ONE) begin
         errors++; $display("FAIL t6_coords: got %0d r2=%h want 2 r2=%h", got, first_r2, R2_ONE);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cutoff();
      test_backpressure();
      test_random_cutoff();
      test_extremes();
      test_reset_mid_sweep();
      test_busy_ignore();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
